c_element: RTL and testbench

- Muller C-element block for the MouseTrap asynchronous NoC handshake path.
- Applies the same C-element rule to two inputs A, B and drives three independent outputs:
  - C1: behavioural, asynchronous.
  - C2: majority-gate with feedback, asynchronous.
  - C3: clock-synchronised, registered.
- Acts as handshake join and as a self-check: C1 and C2 must always agree, and C3 tracks them with fixed latency.

---
 rtl/c_element_if.sv | 27 ++
 rtl/c_element.sv | 119 +++++++++++
 tb/tb_c_element.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/c_element_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : c_element_if
// Purpose : Handshake bundle for the Muller C-element block. It groups the two
//           handshake inputs and the three C-element outputs.
// Signals : A, B        - handshake inputs, one bit per lane
//           C1          - behavioural asynchronous C-element output
//           C2          - majority-gate asynchronous C-element output
//           C3          - synchronised, registered C-element output
// Modports: master      - drives A/B and observes C1..C3 (environment side)
//           slave       - observes A/B and drives C1..C3 (c_element side)
// Revision: 1.0 - initial release
// ============================================================================
interface c_element_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C1;
  logic [WIDTH-1:0] C2;
  logic [WIDTH-1:0] C3;

  modport master (output A, output B, input C1, input C2, input C3);
  modport slave  (input A, input B, output C1, output C2, output C3);
endinterface
`default_nettype wire

// File: rtl/c_element.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : c_element
// Purpose : WIDTH independent Muller C-elements for the MouseTrap handshake
//           path. Each lane applies the same rule three ways:
//             C1 - behavioural level-sensitive element (no clock)
//             C2 - majority gate with its own feedback state (no clock)
//             C3 - inputs pass through a SYNC_STAGES-deep synchroniser and the
//                  element is evaluated on each rising clk edge
//           Rule: A=B=1 -> 1, A=B=0 -> 0, A!=B -> hold.
// Ports   : clk       - clock for the C3 path only
//           extReset  - asynchronous active-high reset of every state element
//           bus       - c_element_if slave: A, B in; C1, C2, C3 out
// Params  : WIDTH       - number of lanes
//           SYNC_STAGES - synchroniser depth in front of C3, 0..4
//                         (0 feeds A/B straight into the C3 register)
// Revision: 1.0 - initial release
// ============================================================================
module c_element #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic   clk,
  input  wire logic   extReset,
  c_element_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Asynchronous elements, one pair per lane
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic r_c1;
      logic r_c2;
      logic w_set;
      logic w_clr;

      // maj(A, B, q) is forced to 1 when A=B=1 and to 0 when A=B=0; with A!=B
      // it returns q. The feedback path is therefore a set/clear storage node.
      assign w_set = bus.A[gi] & bus.B[gi];
      assign w_clr = ~(bus.A[gi] | bus.B[gi]);

      // Behavioural form: transparent while the inputs agree, opaque while
      // they differ. Reset dominates so A/B are ignored while it is high.
      always_latch begin
        if (extReset) begin
          r_c1 <= 1'b0;
        end else if (bus.A[gi] == bus.B[gi]) begin
          r_c1 <= bus.A[gi];
        end
      end

      // Majority-gate form, kept as a separate storage node so that any
      // disagreement with C1 exposes a fault in either implementation.
      always_latch begin
        if (extReset) begin
          r_c2 <= 1'b0;
        end else if (w_set | w_clr) begin
          r_c2 <= w_set;
        end
      end

      assign bus.C1[gi] = r_c1;
      assign bus.C2[gi] = r_c2;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Synchroniser in front of the clocked element
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_a_sync;
  logic [WIDTH-1:0] w_b_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_a_sync = bus.A;
      assign w_b_sync = bus.B;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] r_a_sync;
      logic [SYNC_STAGES-1:0][WIDTH-1:0] r_b_sync;

      always_ff @(posedge clk or posedge extReset) begin
        if (extReset) begin
          r_a_sync <= '0;
          r_b_sync <= '0;
        end else begin
          r_a_sync[0] <= bus.A;
          r_b_sync[0] <= bus.B;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_a_sync[i] <= r_a_sync[i-1];
            r_b_sync[i] <= r_b_sync[i-1];
          end
        end
      end

      assign w_a_sync = r_a_sync[SYNC_STAGES-1];
      assign w_b_sync = r_b_sync[SYNC_STAGES-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Clocked element: SYNC_STAGES+1 rising edges from a stable input change
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_c3;

  always_ff @(posedge clk or posedge extReset) begin
    if (extReset) begin
      r_c3 <= '0;
    end else begin
      r_c3 <= (w_a_sync & w_b_sync) | (r_c3 & (w_a_sync | w_b_sync));
    end
  end

  assign bus.C3 = r_c3;

endmodule
`default_nettype wire

// File: tb/tb_c_element.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_c_element
// Purpose : Self-checking bench for c_element (WIDTH=4, SYNC_STAGES=2).
//           Stimulus pushes expected outputs into a scoreboard queue and
//           strobes an event; a monitor process pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_c_element;

  localparam int W = 4;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    logic [W-1:0] c3;
    logic         chk12;
    logic         chk3;
  } exp_t;

  logic clk;
  logic rst;

  c_element_if #(.WIDTH(W)) bus ();

  c_element #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk      (clk),
    .extReset (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  exp_t  sb[$];
  string sb_nm[$];
  event  ev_chk;
  int    c1_changes = 0;

  always @(bus.C1) c1_changes++;

  function automatic logic [W-1:0] celem(logic [W-1:0] a, logic [W-1:0] b,
                                         logic [W-1:0] c);
    return (a & b) | (c & (a | b));
  endfunction

  task automatic cmp(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(string nm, logic [W-1:0] e1, logic [W-1:0] e2,
                      logic [W-1:0] e3, logic k12, logic k3);
    exp_t e;
    e.c1 = e1; e.c2 = e2; e.c3 = e3; e.chk12 = k12; e.chk3 = k3;
    sb.push_back(e);
    sb_nm.push_back(nm);
    -> ev_chk;
  endtask

  task automatic expect3(string nm, logic [W-1:0] e);
    push(nm, e, e, e, 1'b1, 1'b1);
  endtask

  task automatic expect12(string nm, logic [W-1:0] e);
    push(nm, e, e, '0, 1'b1, 1'b0);
  endtask

  task automatic expectc3(string nm, logic [W-1:0] e);
    push(nm, '0, '0, e, 1'b0, 1'b1);
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: drains the scoreboard each time a check strobe is raised
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(ev_chk);
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        nm = sb_nm.pop_front();
        if (e.chk12) begin
          cmp({nm, "/C1"}, bus.C1, e.c1);
          cmp({nm, "/C2"}, bus.C2, e.c2);
        end
        if (e.chk3) cmp({nm, "/C3"}, bus.C3, e.c3);
      end
    end
  end

  logic [W-1:0] m_c1, h0, h1, h2;
  int           chg0;

  initial begin
    rst   = 1'b1;
    bus.A = '0;
    bus.B = '0;

    // Reset and release
    #45;
    expect3("reset_idle", 4'h0);
    bus.A = 4'hF; bus.B = 4'hF;
    #3;
    expect3("in_reset_ab11", 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect12("release_c1c2", 4'hF);
    expectc3("release_c3", 4'h0);
    edges(S);
    expectc3("release_c3_early", 4'h0);
    edges(1);
    expectc3("release_c3_lat", 4'hF);

    // Hold behaviour
    @(negedge clk); bus.A = 4'h0; #1;
    expect3("hold_a0", 4'hF);
    edges(4);
    expectc3("hold_a0_c3", 4'hF);
    @(negedge clk); bus.B = 4'h0; #1;
    expect12("clear_c1c2", 4'h0);
    expectc3("clear_c3_held", 4'hF);
    edges(S);
    expectc3("clear_c3_early", 4'hF);
    edges(1);
    expectc3("clear_c3_lat", 4'h0);
    @(negedge clk); bus.A = 4'hF; #1;
    expect3("hold_a1_b0", 4'h0);
    edges(4);
    expectc3("hold_a1_b0_c3", 4'h0);

    // Simultaneous transitions
    @(negedge clk); bus.A = 4'h0; #1;
    chg0 = c1_changes;
    @(negedge clk); bus.A = 4'hF; bus.B = 4'hF; #1;
    expect12("simul_set", 4'hF);
    cmp("simul_set_c1_events", W'(c1_changes - chg0), W'(1));
    edges(S + 1);
    expectc3("simul_set_c3", 4'hF);
    chg0 = c1_changes;
    @(negedge clk); bus.A = 4'h0; bus.B = 4'h0; #1;
    expect12("simul_clr", 4'h0);
    cmp("simul_clr_c1_events", W'(c1_changes - chg0), W'(1));
    edges(S + 1);
    expectc3("simul_clr_c3", 4'h0);

    // Reset mid-operation, between clock edges
    @(negedge clk); bus.A = 4'hF; bus.B = 4'hF;
    edges(S + 1);
    expect3("pre_midrst", 4'hF);
    @(negedge clk); #2 rst = 1'b1; #1;
    expect3("midrst", 4'h0);
    bus.B = 4'h0;
    #1 rst = 1'b0; #1;
    expect3("midrst_release_a1b0", 4'h0);
    edges(4);
    expectc3("midrst_release_c3", 4'h0);

    // Multi-lane independence
    @(negedge clk); rst = 1'b1; bus.A = '0; bus.B = '0;
    #2 bus.A = 4'b1100; bus.B = 4'b1010;
    #2 rst = 1'b0; #1;
    expect12("lanes_set", 4'b1000);
    expectc3("lanes_set_c3_early", 4'b0000);
    edges(S + 1);
    expectc3("lanes_set_c3", 4'b1000);
    @(negedge clk); bus.A = 4'b0000; #1;
    expect12("lanes_hold", 4'b1000);
    edges(S + 1);
    expectc3("lanes_hold_c3", 4'b1000);
    @(negedge clk); bus.B = 4'b0000; #1;
    expect12("lanes_clr", 4'b0000);
    edges(S + 1);
    expectc3("lanes_clr_c3", 4'b0000);

    // Random stimulus against a reference model (state is all-zero here)
    m_c1 = '0; h0 = '0; h1 = '0; h2 = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      #1;
      m_c1 = celem(bus.A, bus.B, m_c1);
      expect12("rnd_async", m_c1);
      @(posedge clk);
      // C3 after edge k equals the sampled model two edges earlier
      h2 = h1; h1 = h0; h0 = celem(bus.A, bus.B, h0);
      #1;
      expectc3("rnd_c3", h2);
    end

    #1;
    cmp("scoreboard_drained", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
